// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked RV32I ALU with iterative RV32M mul/div for the copperv execute stage.
// Define COPPERV_ALU_MULDIV_EN to build ops 10-17; otherwise they report out_err.
module multicycle_alu #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_din1,
    input  logic [DATA_WIDTH-1:0] in_din2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [2:0]            out_comp,
    output logic                  out_err
);
    localparam int unsigned W = DATA_WIDTH;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic                   accept;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [2:0]             comp;
    logic [W-1:0]           fast_result;
    logic                   fast_err;
    logic                   start_multi;

    assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign shamt    = in_din2[SHAMT_WIDTH-1:0];
    assign comp     = {in_din1 < in_din2, $signed(in_din1) < $signed(in_din2), in_din1 == in_din2};

`ifdef COPPERV_ALU_MULDIV_EN
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]           hi_q, lo_q, opb_q;
    logic [4:0]             op_q;
    logic                   neg_res_q, neg_rem_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic                   s1, s2;
    logic [W-1:0]           mag1, mag2;
    logic [W-1:0]           set_lo, set_opb;
    logic                   set_neg_res, set_neg_rem;
    logic [W:0]             mul_sum, div_tmp;
    logic [W-1:0]           div_diff;
    logic [W-1:0]           hi_nxt, lo_nxt;
    logic [2*W-1:0]         prod, prod_fix;
    logic [W-1:0]           final_result;

    assign s1   = in_din1[W-1];
    assign s2   = in_din2[W-1];
    assign mag1 = s1 ? -in_din1 : in_din1;
    assign mag2 = s2 ? -in_din2 : in_din2;

    // Operand magnitudes and sign fix-up flags latched at accept.
    always_comb begin
        set_lo      = in_din2;
        set_opb     = in_din1;
        set_neg_res = 1'b0;
        set_neg_rem = 1'b0;
        case (in_op)
            OP_MULH: begin
                set_lo      = mag2;
                set_opb     = mag1;
                set_neg_res = s1 ^ s2;
            end
            OP_MULHSU: begin
                set_opb     = mag1;
                set_neg_res = s1;
            end
            OP_DIV: begin
                set_lo      = mag1;
                set_opb     = mag2;
                set_neg_res = s1 ^ s2;
            end
            OP_REM: begin
                set_lo      = mag1;
                set_opb     = mag2;
                set_neg_rem = s1;
            end
            OP_DIVU, OP_REMU: begin
                set_lo  = in_din1;
                set_opb = in_din2;
            end
            default: ;
        endcase
    end

    // One radix-2 step: right-shifting shift-add, or restoring shift-subtract into {rem, quot}.
    always_comb begin
        hi_nxt   = hi_q;
        lo_nxt   = lo_q;
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        div_tmp  = {hi_q, lo_q[W-1]};
        div_diff = div_tmp[W-1:0] - opb_q;
        if (op_q < OP_DIV) begin
            hi_nxt = mul_sum[W:1];
            lo_nxt = {mul_sum[0], lo_q[W-1:1]};
        end else if (div_tmp >= {1'b0, opb_q}) begin
            hi_nxt = div_diff;
            lo_nxt = {lo_q[W-2:0], 1'b1};
        end else begin
            hi_nxt = div_tmp[W-1:0];
            lo_nxt = {lo_q[W-2:0], 1'b0};
        end
    end

    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_res_q ? -prod : prod;
        case (op_q)
            OP_MUL:                       final_result = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              final_result = neg_res_q ? -lo_nxt : lo_nxt;
            default:                      final_result = neg_rem_q ? -hi_nxt : hi_nxt;
        endcase
    end
`endif

    // Single-cycle results, including the div-by-zero and signed-overflow corner cases.
    always_comb begin
        fast_result = '0;
        fast_err    = 1'b0;
        start_multi = 1'b0;
        case (in_op)
            OP_ADD:  fast_result = in_din1 + in_din2;
            OP_SUB:  fast_result = in_din1 - in_din2;
            OP_AND:  fast_result = in_din1 & in_din2;
            OP_OR:   fast_result = in_din1 | in_din2;
            OP_XOR:  fast_result = in_din1 ^ in_din2;
            OP_SLL:  fast_result = in_din1 << shamt;
            OP_SRL:  fast_result = in_din1 >> shamt;
            OP_SRA:  fast_result = $signed(in_din1) >>> shamt;
            OP_SLT:  fast_result = W'(comp[1]);
            OP_SLTU: fast_result = W'(comp[2]);
`ifdef COPPERV_ALU_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: start_multi = 1'b1;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (in_din2 == '0) begin
                    fast_result = (in_op == OP_DIV || in_op == OP_DIVU) ? {W{1'b1}} : in_din1;
                end else if ((in_op == OP_DIV || in_op == OP_REM) &&
                             in_din1 == MOST_NEG && in_din2 == {W{1'b1}}) begin
                    fast_result = (in_op == OP_DIV) ? in_din1 : '0;
                end else begin
                    start_multi = 1'b1;
                end
            end
`endif
            default: fast_err = 1'b1;
        endcase
    end

    // Control FSM with registered result, flags and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_comp   <= '0;
            out_err    <= 1'b0;
`ifdef COPPERV_ALU_MULDIV_EN
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        out_comp <= comp;
                        out_err  <= fast_err;
`ifdef COPPERV_ALU_MULDIV_EN
                        if (start_multi) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            hi_q      <= '0;
                            lo_q      <= set_lo;
                            opb_q     <= set_opb;
                            op_q      <= in_op;
                            neg_res_q <= set_neg_res;
                            neg_rem_q <= set_neg_rem;
                            cnt_q     <= '0;
                        end else
`endif
                        begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= fast_result;
                        end
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef COPPERV_ALU_MULDIV_EN
                BUSY: begin
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHAMT_WIDTH'(W - 1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= final_result;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed cases plus random ops against an arithmetic reference model.
module tb_multicycle_alu;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, out_err;
    logic [4:0]   in_op;
    logic [W-1:0] in_din1, in_din2, out_result;
    logic [2:0]   out_comp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_din1    (in_din1),
        .in_din2    (in_din2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_comp   (out_comp),
        .out_err    (out_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from wide integer arithmetic, latency from the op class.
    function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic err, output int lat,
                                  output logic [2:0] comp);
        longint     sa, sb;
        logic [63:0] ua, ub, p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        p    = '0;
        res  = '0;
        err  = 1'b0;
        lat  = 1;
        comp = {ua < ub, sa < sb, a == b};
        case (op)
            5'd0: res = a + b;
            5'd1: res = a - b;
            5'd2: res = a & b;
            5'd3: res = a | b;
            5'd4: res = a ^ b;
            5'd5: res = a << b[4:0];
            5'd6: res = a >> b[4:0];
            5'd7: res = W'(sa >>> b[4:0]);
            5'd8: res = W'(sa < sb);
            5'd9: res = W'(ua < ub);
`ifdef COPPERV_ALU_MULDIV_EN
            5'd10: begin p = ua * ub;               res = p[31:0];  lat = 33; end
            5'd11: begin p = 64'(sa * sb);          res = p[63:32]; lat = 33; end
            5'd12: begin p = 64'(sa * longint'(ub)); res = p[63:32]; lat = 33; end
            5'd13: begin p = ua * ub;               res = p[63:32]; lat = 33; end
            5'd14: begin
                if (b == 0) res = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
                else begin res = W'(sa / sb); lat = 33; end
            end
            5'd15: begin
                if (b == 0) res = '1;
                else begin res = W'(ua / ub); lat = 33; end
            end
            5'd16: begin
                if (b == 0) res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = '0;
                else begin res = W'(sa % sb); lat = 33; end
            end
            5'd17: begin
                if (b == 0) res = a;
                else begin res = W'(ua % ub); lat = 33; end
            end
`endif
            default: err = 1'b1;
        endcase
    endfunction

    // Issue one op, hold the result for 'stall' cycles, then consume it and confirm the return to idle.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int stall);
        logic [W-1:0] er;
        logic         ee;
        int           el;
        logic [2:0]   ec;
        int           lat;
        int           budget;
        logic         busy_bad;
        model(op, a, b, er, ee, el, ec);
        in_valid = 1'b1; in_op = op; in_din1 = a; in_din2 = b;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
        check({tag, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_din1 = $urandom; in_din2 = $urandom; in_op = 5'($urandom_range(0, 31));
        busy_bad = 1'b0;
        lat = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(el));
        check({tag, "_busy_ready"}, 64'(busy_bad), 64'd0);
        check({tag, "_res"}, 64'(out_result), 64'(er));
        check({tag, "_err"}, 64'(out_err), 64'(ee));
        check({tag, "_comp"}, 64'(out_comp), 64'(ec));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold_res"}, {out_valid, out_err, out_comp, out_result},
                  {1'b1, ee, ec, er});
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ready_done"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        check({tag, "_idle"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic         bad;
        logic [4:0]   rop;
        logic [W-1:0] ra, rb;

        rst = 1'b1; in_valid = 1'b1; in_op = 5'd0; in_din1 = 32'd3; in_din2 = 32'd4; out_ready = 1'b1;

        // Reset held with in_valid asserted.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 64'(in_ready), 64'd0);
            check("rst_out", {out_valid, out_err, out_comp, out_result}, 64'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Back-to-back single-cycle ops at one per cycle.
        in_valid = 1'b1; in_op = 5'd1; in_din1 = 32'd5; in_din2 = 32'd7; out_ready = 1'b1;
        @(posedge clk); #1;
        in_op = 5'd7; in_din1 = 32'h8000_0000; in_din2 = 32'h24;
        @(negedge clk);
        check("b2b_sub", {out_valid, out_comp, out_result}, {1'b1, 3'b110, 32'hFFFF_FFFE});
        check("b2b_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_op = 5'd9; in_din1 = 32'd1; in_din2 = 32'hFFFF_FFFF;
        @(negedge clk);
        check("b2b_sra", {out_valid, out_result}, {1'b1, 32'hF800_0000});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_sltu", {out_valid, out_result}, {1'b1, 32'd1});
        @(negedge clk);
        check("b2b_idle", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        run_op("mulh_neg1", 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_ovf",   5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf",   5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("remu_z",    5'd17, 32'd7, 32'd0, 0);
        run_op("divu_z",    5'd15, 32'd7, 32'd0, 0);
        run_op("div_m7",    5'd14, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7",    5'd16, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("mulhsu",    5'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1);
        run_op("mul",       5'd10, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("add_stall", 5'd0, 32'd1, 32'd2, 5);
        run_op("illegal20", 5'd20, 32'd9, 32'd9, 0);
        run_op("illegal31", 5'd31, 32'd1, 32'd2, 1);

        // Reset ten cycles into a long op (or into a held result) must drop everything.
        in_valid = 1'b1; in_op = 5'd15; in_din1 = 32'd100; in_din2 = 32'd3; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check("abort_no_valid", 64'(bad), 64'd0);
        check("abort_result", 64'(out_result), 64'd0);
        out_ready = 1'b0;
        run_op("add_after_abort", 5'd0, 32'd2, 32'd2, 0);

        // Random ops and operands.
        for (int n = 0; n < 150; n++) begin
            rop = 5'($urandom_range(0, 19));
            ra  = pick();
            rb  = pick();
            run_op("rand", rop, ra, rb, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
